// File: rtl/sobel_window_gen.sv
// Turns an {R,G,B} pixel stream into 3x3 single-channel windows for the Sobel stage.
// Two line buffers plus a 3x3 shift register; one window per accepted pixel once fully inside the frame.
module sobel_window_gen #(
    parameter int IMG_W = 640,
    parameter int PIX_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_en1,
    input  logic                 w_en2,
    input  logic                 w_en3,
    input  logic                 pix_valid,
    input  logic                 pix_sof,
    input  logic [3*PIX_W-1:0]   pix_data,
    output logic                 pix_ready,
    output logic                 win_valid,
    input  logic                 win_ready,
    output logic [9*PIX_W-1:0]   win_data
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = 16;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FILL = 2'd1, ST_STREAM = 2'd2} state_t;
    typedef enum logic [1:0] {CH_R = 2'd0, CH_G = 2'd1, CH_B = 2'd2} chan_t;

    function automatic logic [PIX_W-1:0] pick_channel(input chan_t ch, input logic [3*PIX_W-1:0] px);
        case (ch)
            CH_R:    return px[3*PIX_W-1 -: PIX_W];
            CH_G:    return px[2*PIX_W-1 -: PIX_W];
            CH_B:    return px[PIX_W-1:0];
            default: return px[3*PIX_W-1 -: PIX_W];
        endcase
    endfunction

    state_t               state_r;
    chan_t                chan_r;
    logic [COL_W-1:0]     col_r;
    logic [ROW_W-1:0]     row_r;
    logic                 ready_en_r;
    logic                 win_valid_r;
    logic [9*PIX_W-1:0]   win_data_r;
    logic [PIX_W-1:0]     lb1_r [0:IMG_W-1];
    logic [PIX_W-1:0]     lb2_r [0:IMG_W-1];
    logic [PIX_W-1:0]     win_r [0:2][0:2];

    logic                 accept_s;
    logic                 any_en_s;
    chan_t                sof_chan_s;
    chan_t                cur_chan_s;
    logic [PIX_W-1:0]     cur_pix_s;
    logic [COL_W-1:0]     wr_col_s;
    logic [PIX_W-1:0]     lb1_rd_s;
    logic [PIX_W-1:0]     lb2_rd_s;
    logic                 store_s;
    logic                 emit_s;
    logic [PIX_W-1:0]     nw_s [0:2][0:2];
    logic [9*PIX_W-1:0]   next_data_s;

    assign pix_ready = ready_en_r && (!win_valid_r || win_ready);
    assign win_valid = win_valid_r;
    assign win_data  = win_data_r;
    assign accept_s  = pix_valid && pix_ready;

    // Channel choice, buffer addressing and the store/emit decisions for the current pixel.
    always_comb begin
        any_en_s = w_en1 || w_en2 || w_en3;
        if (w_en1) begin
            sof_chan_s = CH_R;
        end else if (w_en2) begin
            sof_chan_s = CH_B;
        end else begin
            sof_chan_s = CH_G;
        end
        // An SOF pixel is (0,0) of a new frame, so it uses the fresh channel and column 0.
        if (pix_sof) begin
            cur_chan_s = sof_chan_s;
            wr_col_s   = {COL_W{1'b0}};
            store_s    = accept_s && any_en_s;
        end else begin
            cur_chan_s = chan_r;
            wr_col_s   = col_r;
            store_s    = accept_s && (state_r != ST_IDLE);
        end
        cur_pix_s = pick_channel(cur_chan_s, pix_data);
        lb1_rd_s  = lb1_r[wr_col_s];
        lb2_rd_s  = lb2_r[wr_col_s];
        emit_s    = accept_s && !pix_sof && (state_r == ST_STREAM) && (col_r >= COL_W'(2));
    end

    // Next window: shift columns left, load {line y-2, line y-1, current} on the right; pack row-major.
    always_comb begin
        next_data_s = {9*PIX_W{1'b0}};
        for (int r = 0; r < 3; r++) begin
            nw_s[r][0] = win_r[r][1];
            nw_s[r][1] = win_r[r][2];
        end
        nw_s[0][2] = lb2_rd_s;
        nw_s[1][2] = lb1_rd_s;
        nw_s[2][2] = cur_pix_s;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                next_data_s[(8-(r*3+c))*PIX_W +: PIX_W] = nw_s[r][c];
            end
        end
    end

    // Frame FSM, position counters and the single-entry output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            chan_r      <= CH_R;
            col_r       <= {COL_W{1'b0}};
            row_r       <= {ROW_W{1'b0}};
            ready_en_r  <= 1'b0;
            win_valid_r <= 1'b0;
            win_data_r  <= {9*PIX_W{1'b0}};
        end else begin
            ready_en_r <= 1'b1;
            if (accept_s && pix_sof) begin
                col_r <= COL_W'(1);
                row_r <= {ROW_W{1'b0}};
                if (any_en_s) begin
                    state_r <= ST_FILL;
                    chan_r  <= sof_chan_s;
                end else begin
                    state_r <= ST_IDLE;
                end
            end else if (accept_s && (state_r != ST_IDLE)) begin
                if (state_r == ST_FILL && row_r == ROW_W'(2) && col_r == COL_W'(0)) begin
                    state_r <= ST_STREAM;
                end
                if (col_r == COL_W'(IMG_W-1)) begin
                    col_r <= {COL_W{1'b0}};
                    if (row_r != {ROW_W{1'b1}}) begin
                        row_r <= row_r + ROW_W'(1);
                    end
                end else begin
                    col_r <= col_r + COL_W'(1);
                end
            end
            if (accept_s) begin
                win_valid_r <= emit_s;
            end else if (win_ready) begin
                win_valid_r <= 1'b0;
            end
            if (emit_s) begin
                win_data_r <= next_data_s;
            end
        end
    end

    // Window shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_r[r][c] <= {PIX_W{1'b0}};
                end
            end
        end else if (store_s) begin
            win_r <= nw_s;
        end
    end

    // Line buffers, read-before-write: line y-2 inherits the old line y-1 entry.
    always_ff @(posedge clk) begin
        if (store_s) begin
            lb2_r[wr_col_s] <= lb1_rd_s;
            lb1_r[wr_col_s] <= cur_pix_s;
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen with IMG_W=4: expected windows come from a bench-side image copy.
module tb_sobel_window_gen;

    localparam int IMG_W = 4;
    localparam int PIX_W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w_en1 = 1'b0, w_en2 = 1'b0, w_en3 = 1'b0;
    logic        pix_valid = 1'b0, pix_sof = 1'b0;
    logic [23:0] pix_data = 24'h0;
    logic        pix_ready;
    logic        win_valid;
    logic        win_ready = 1'b1;
    logic [71:0] win_data;

    int          vectors = 0;
    int          miscompares = 0;
    int          win_cnt = 0;
    logic [71:0] first_win = 72'h0;
    logic [71:0] exp_q [$];
    logic [7:0]  img [0:7][0:3];

    sobel_window_gen #(.IMG_W(IMG_W), .PIX_W(PIX_W)) dut (
        .clk(clk), .rst(rst), .w_en1(w_en1), .w_en2(w_en2), .w_en3(w_en3),
        .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data), .pix_ready(pix_ready),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data)
    );

    always #5 clk = ~clk;

    task automatic monitor();
        logic [71:0] e;
        forever begin
            @(negedge clk);
            if (!rst && win_valid && win_ready) begin
                win_cnt++;
                vectors++;
                if (win_cnt == 1) first_win = win_data;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_window got=%h expected=none", win_data);
                end else begin
                    e = exp_q.pop_front();
                    if (win_data !== e) begin
                        miscompares++;
                        $display("FAIL window_data got=%h expected=%h", win_data, e);
                    end
                end
            end
        end
    endtask

    task automatic send_pixel(input int x, input int y, input logic sof, input logic [23:0] d,
                              input logic [7:0] ch, input logic keep);
        int   n = 0;
        logic acc = 1'b0;
        logic exp_v;
        pix_valid = 1'b1; pix_sof = sof; pix_data = d;
        while (!acc && n < 50) begin
            @(negedge clk);
            if (pix_ready) acc = 1'b1;
            n++;
            @(posedge clk); #1;
        end
        vectors++;
        if (!acc) begin
            miscompares++;
            $display("FAIL pix_accept_timeout x=%0d y=%0d got=not_accepted expected=accepted", x, y);
        end else begin
            img[y][x] = ch;
            exp_v = keep && x >= 2 && y >= 2;
            if (exp_v)
                exp_q.push_back({img[y-2][x-2], img[y-2][x-1], img[y-2][x],
                                 img[y-1][x-2], img[y-1][x-1], img[y-1][x],
                                 img[y][x-2],   img[y][x-1],   img[y][x]});
            if (win_valid !== exp_v) begin
                miscompares++;
                $display("FAIL win_valid_after_pixel x=%0d y=%0d got=%b expected=%b", x, y, win_valid, exp_v);
            end
        end
        pix_valid = 1'b0; pix_sof = 1'b0;
    endtask

    task automatic run_frame(input int rows, input int chsel, input logic [7:0] base, input logic keep);
        logic [23:0] d;
        logic [7:0]  ch;
        for (int y = 0; y < rows; y++) begin
            for (int x = 0; x < IMG_W; x++) begin
                d = {8'(base + y*4 + x), 8'(8'h40 + y*4 + x), 8'(8'h80 + y*4 + x)};
                ch = (chsel == 0) ? d[23:16] : (chsel == 1) ? d[15:8] : d[7:0];
                send_pixel(x, y, (x == 0 && y == 0), d, ch, keep);
            end
        end
    endtask

    task automatic drain(input string name, input int exp_cnt);
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (win_cnt != exp_cnt) begin
            miscompares++;
            $display("FAIL %s_window_count got=%0d expected=%0d", name, win_cnt, exp_cnt);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_missing_windows got=%0d_pending expected=0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors += 3;
        if (win_valid !== 1'b0) begin miscompares++; $display("FAIL reset_win_valid got=%b expected=0", win_valid); end
        if (pix_ready !== 1'b0) begin miscompares++; $display("FAIL reset_pix_ready got=%b expected=0", pix_ready); end
        if (win_data !== 72'h0) begin miscompares++; $display("FAIL reset_win_data got=%h expected=0", win_data); end
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (pix_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_reset got=%b expected=1", pix_ready); end
        // Stream three rows, then reset asynchronously just after a window was produced.
        w_en1 = 1'b1;
        win_cnt = 0;
        run_frame(3, 0, 8'h00, 1'b1);
        #2 rst = 1'b1;
        #1;
        vectors += 2;
        if (win_valid !== 1'b0) begin miscompares++; $display("FAIL async_reset_win_valid got=%b expected=0", win_valid); end
        if (pix_ready !== 1'b0) begin miscompares++; $display("FAIL async_reset_pix_ready got=%b expected=0", pix_ready); end
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        win_cnt = 0;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < IMG_W; x++)
                send_pixel(x, y, 1'b0, 24'h123456, 8'h12, 1'b0);
        drain("reset_no_sof", 0);
    endtask

    task automatic test_red_frame();
        w_en1 = 1'b1; w_en2 = 1'b0; w_en3 = 1'b0;
        win_cnt = 0;
        run_frame(4, 0, 8'h00, 1'b1);
        drain("red", 4);
        vectors++;
        if (first_win !== 72'h00_01_02_04_05_06_08_09_0A) begin
            miscompares++;
            $display("FAIL red_first_window got=%h expected=00010204050608090a", first_win);
        end
    endtask

    task automatic test_priority();
        w_en1 = 1'b0; w_en2 = 1'b1; w_en3 = 1'b1;
        win_cnt = 0;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < IMG_W; x++) begin
                if (y == 1 && x == 0) begin w_en1 = 1'b1; w_en2 = 1'b0; end
                send_pixel(x, y, (x == 0 && y == 0), 24'hAA1155, 8'h55, 1'b1);
            end
        end
        drain("priority", 4);
    endtask

    task automatic test_backpressure();
        logic [71:0] cap;
        w_en1 = 1'b0; w_en2 = 1'b0; w_en3 = 1'b1;
        win_cnt = 0;
        fork
            run_frame(4, 1, 8'h20, 1'b1);
            begin
                for (int n = 0; n < 100; n++) begin
                    @(posedge clk); #1;
                    if (win_valid) break;
                end
                win_ready = 1'b0;
                cap = win_data;
                repeat (5) begin
                    @(negedge clk);
                    vectors += 3;
                    if (pix_ready !== 1'b0) begin miscompares++; $display("FAIL stall_pix_ready got=%b expected=0", pix_ready); end
                    if (win_valid !== 1'b1) begin miscompares++; $display("FAIL stall_win_valid got=%b expected=1", win_valid); end
                    if (win_data !== cap) begin miscompares++; $display("FAIL stall_win_data got=%h expected=%h", win_data, cap); end
                end
                @(posedge clk); #1;
                win_ready = 1'b1;
            end
        join
        drain("backpressure", 4);
    endtask

    task automatic test_mid_sof();
        w_en1 = 1'b1; w_en2 = 1'b0; w_en3 = 1'b0;
        win_cnt = 0;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < IMG_W; x++)
                if (y < 3 || x == 0)
                    send_pixel(x, y, (x == 0 && y == 0), {8'(y*4 + x), 16'h0}, 8'(y*4 + x), 1'b1);
        // The pixel at (1,3) carries SOF and becomes (0,0) of a new frame.
        run_frame(3, 0, 8'hC0, 1'b1);
        drain("mid_sof", 4);
        w_en1 = 1'b0;
        win_cnt = 0;
        run_frame(4, 0, 8'h60, 1'b0);
        drain("no_channel_sof", 0);
    endtask

    task automatic test_line_wrap();
        logic [23:0] d;
        w_en1 = 1'b1;
        win_cnt = 0;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < IMG_W; x++) begin
                d = 24'($urandom);
                send_pixel(x, y, (x == 0 && y == 0), d, d[23:16], 1'b1);
            end
        end
        drain("line_wrap", 4);
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_red_frame();
        test_priority();
        test_backpressure();
        test_mid_sof();
        test_line_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Converts the raw RGB pixel stream into 3x3 single-channel windows for the Sobel kernel. The channel is selected by the colour-mode FSM's write enables (w_en1 red, w_en2 blue, w_en3 green). The block sits between the pixel source and the Sobel arithmetic stage. It buffers two image lines and emits one window per accepted pixel once the window is fully inside the frame.

## Interface
- IMG_W, 640: pixels per line; minimum 3.
- PIX_W, 8: bits per colour channel.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- w_en1  in  1  select red channel (highest priority).
- w_en2  in  1  select blue channel.
- w_en3  in  1  select green channel (lowest priority).
- pix_valid  in  1  input pixel valid.
- pix_sof  in  1  qualifies the current pixel as frame start (x=0, y=0).
- pix_data  in  3*PIX_W  {R,G,B}; R in MSBs.
- pix_ready  out  1  block accepts pixel this cycle.
- win_valid  out  1  window valid.
- win_ready  in  1  downstream accepts window.
- win_data  out  9*PIX_W  window, row-major.
  - MSB slice is top-left (x-2, y-2).
  - LSB slice is bottom-right (x, y): the pixel just accepted.

## Operation
- A pixel is accepted on a cycle where pix_valid && pix_ready.
- Channel latch, taken on the accepted pixel carrying pix_sof:
  - w_en1 → R; else w_en2 → B; else w_en3 → G.
  - If none is asserted, the pixel is dropped and the block stays IDLE.
  - Changes to w_en* mid-frame are ignored until the next accepted SOF.
- States:
  - IDLE: waiting for an SOF pixel. Non-SOF pixels are accepted and discarded.
  - FILL: rows 0–1 are being written to the line buffers; no windows are emitted.
  - STREAM: row ≥ 2; windows are emitted for x ≥ 2.
- Transitions:
  - IDLE→FILL on an accepted SOF with a channel selected.
  - FILL→STREAM when the first pixel of row 2 is accepted.
  - Any state→FILL on an accepted SOF with a channel selected. This aborts the current frame and restarts counters at (0,0).
  - Any state→IDLE on an accepted SOF with no channel selected.
- Counters:
  - col (ceil(log2(IMG_W)) bits) wraps from IMG_W-1 to 0 and increments row.
  - row saturates at its maximum; there is no frame-height parameter, so frames end only by the next SOF.
- Line buffers: two IMG_W×PIX_W RAMs (line y-1 and line y-2), read and written at col on each accepted pixel.
  - Read-before-write: line y-2 takes the old contents of line y-1.
  - Contents are not reset; they are never exposed because FILL suppresses output.
- Window shift register: 3×3 registers. Each accepted pixel shifts columns left and loads {line y-2, line y-1, current} into the right column.
- Windows never span a line boundary: win_valid is raised only for col ≥ 2 of the accepted pixel.

## Timing
- Reset values: win_valid=0, win_data=0, pix_ready=0, state IDLE, col=row=0, channel=R.
- pix_ready rises the first cycle after reset deasserts.
  - pix_ready = !win_valid || win_ready (single-entry output stage).
- Latency: an accepted pixel at (x≥2, y≥2) in STREAM gives win_valid=1 on the next clock edge.
- Stall: while win_valid && !win_ready, win_data and win_valid hold and pix_ready=0.
- Throughput: one window per clock with continuous valid/ready.
- Accepted pixel with x<2 or y<2: win_valid clears on the next edge if the old window was taken (or none was pending).
- Asynchronous reset mid-frame: outputs go to reset values immediately; the next frame requires a new SOF.

## Test plan
- Reset: assert rst mid-stream → win_valid=0, pix_ready=0 at once; after release, non-SOF pixels are dropped with no window.
- Red frame, IMG_W=4, w_en1=1, pixel value R=y*4+x, continuous ready, 4 rows:
  - First window follows pixel (2,2), with win_data = {0,1,2,4,5,6,8,9,10}.
  - Exactly 4 windows per frame.
- Channel priority: w_en2=w_en3=1 at SOF, pixels {R=0xAA, G=0x11, B=0x55} → all window slices are 0x55.
  - Toggling w_en mid-frame does not change the output.
- Backpressure: win_ready held low for 5 cycles → pix_ready=0 and win_data stable.
  - On release, there is no lost or duplicated window; the count still equals 4 per frame.
- Mid-frame SOF at (1,3) → counters restart; the next window appears only after new pixel (2,2).
  - SOF with no w_en asserted → state IDLE, no windows.
- Line wrap: IMG_W=4 → pixels (0,y) and (1,y) never produce windows.
  - The window at (2,y) contains no data from row y-1 columns 2–3 in its left column.
